maxpool2x2_flatten_responder: RTL and testbench
===============================================

Name: maxpool2x2_flatten_responder

Overview:
- Responder end of the dense-layer max-pool handshake (mp_start / mp_done / mp_read_addr / mp_read_data).
- On mp_start, it reads a channel-major 4-bit feature map from upstream memory and performs 2x2 stride-2 max pooling.
- Pooled values are stored as a flattened vector in an internal buffer, then mp_done is pulsed.
- After that, the buffer answers zero-latency reads from the dense layer.

Parameters:
- IN_H, 16, input feature-map height (must be even)
- IN_W, 16, input feature-map width (must be even)
- CHANNELS, 4, number of input channels
- DATA_W, 4, activation width (unsigned ReLU6 codes 0..6)
- FM_ADDR_W, 12, upstream feature-map address width
- Derived locals: OUT_H=IN_H/2, OUT_W=IN_W/2, OUT_LEN=CHANNELS*OUT_H*OUT_W (default 256), BUF_AW=clog2(OUT_LEN)

Ports:
- clk  input  1  single clock; all logic on rising edge
- reset  input  1  synchronous, active-high reset
- mp_start  input  1  request from dense layer; sampled only in IDLE
- mp_done  output  1  one-cycle pulse when the flattened buffer is complete
- mp_read_addr  input  32  flattened read index from dense layer
- mp_read_data  output  DATA_W  buffer[mp_read_addr]; combinational
- fm_addr  output  FM_ADDR_W  upstream feature-map read address (registered)
- fm_data  input  DATA_W  upstream data, valid exactly 1 cycle after fm_addr
- busy  output  1  high in every state except IDLE

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values: mp_done=0, busy=0, fm_addr=0; all buffer entries cleared to 0; state=IDLE; all counters=0.
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - If mp_start=1, clear window/channel counters and go to ISSUE.
  - mp_start in any other state is ignored; no queuing.
- Addressing:
  - Input address = (c*IN_H + y)*IN_W + x.
  - Window (c,oy,ox) covers pixels in order j=0..3: (2oy,2ox), (2oy,2ox+1), (2oy+1,2ox), (2oy+1,2ox+1).
  - Output index = (c*OUT_H + oy)*OUT_W + ox.
  - Windows are processed in increasing output-index order.
- ISSUE: four consecutive cycles per window, driving fm_addr for j=0..3. Then go to DRAIN.
- Max accumulation:
  - The running max register loads fm_data for j=0 and takes max(running, fm_data) for j=1..3.
  - Comparison is unsigned, DATA_W bits; ties keep the existing value.
- DRAIN:
  - One cycle; the j=3 data arrives here.
  - Buffer write of max(running, fm_data) occurs at the end of this cycle.
  - Then go to ISSUE for the next window, or to DONE after the last window.
- Timing, with mp_start sampled in IDLE at cycle k:
  - Window w issues addresses at cycles k+1+5w .. k+4+5w.
  - Window w writes at cycle k+5+5w.
  - mp_done=1 exactly in cycle k+5*OUT_LEN+1 (DONE state), then IDLE.
  - Total latency from start to done is 5*OUT_LEN+1 cycles.
- fm_addr holds its last issued value outside ISSUE.
- Reads:
  - mp_read_data = buffer[mp_read_addr[BUF_AW-1:0]] when mp_read_addr < OUT_LEN, else 0.
  - Pure combinational, zero latency, available in every state.
  - During a run, reads return old contents for entries not yet rewritten; the buffer is never implicitly cleared by mp_start.
- Reset mid-operation: abort immediately, clear the buffer, return to IDLE, no mp_done pulse.
- Back-to-back requests: a start asserted in the cycle after DONE (state IDLE) begins a new run with identical timing.

Decomposition:
- Package pool_flatten_pkg holds:
  - state encoding localparams (IDLE/ISSUE/DRAIN/DONE)
  - DATA_W default and the ReLU6 maximum code constant (6)
  - a clog2 function
  - the address-computation function for (c,y,x)
- Sub-module pool_flat_buffer:
  - OUT_LEN x DATA_W register array
  - one synchronous write port
  - synchronous clear on reset
  - one combinational read port with out-of-range zeroing

Test Plan:
- Constant map (all fm_data=3), start at cycle 0 -> mp_done high exactly at cycle 1281 only; all 256 reads return 3; busy high cycles 1..1281.
- Map value = x%7 in channel 0, else 0 -> output index 0 = 1, index 1 = 3, index 3 = 6 (window x=6,7 gives max(6,0)=6); channel 1-3 entries = 0.
- Single hot pixel (c=2,y=5,x=9)=6, rest 0 -> only index (2*8+2)*8+4=148 reads 6; mp_read_addr=300 reads 0.
- Reset asserted at cycle 400 of a run -> next cycle busy=0, mp_done never pulses; all reads return 0; new start completes normally.
- mp_start held high for the whole run -> exactly one run, a single mp_done pulse; a second run begins the cycle after DONE, and its done pulse arrives 1281 cycles after that start.
- Reads during a run (second run with a different map) -> already-written indices show new values, unwritten indices show old values, with no read-latency cycle.

Source files
------------

// File: rtl/pool_flatten_pkg.sv
// Shared constants and helpers for the 2x2 max-pool / flatten responder.
package pool_flatten_pkg;

  // FSM encoding
  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StIssue = 2'd1;
  localparam logic [1:0] StDrain = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  localparam int unsigned DataW = 4;
  // Largest code a ReLU6 activation can take.
  localparam logic [DataW-1:0] Relu6Max = 4'd6;

  // Ceiling log2, never less than 1 so derived widths stay legal.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int unsigned v = value - 1; v > 0; v = v >> 1) begin
      result = result + 1;
    end
    return (result == 0) ? 1 : result;
  endfunction

  // Channel-major feature-map address of pixel (c, y, x).
  function automatic int unsigned fm_addr_calc(input int unsigned c, input int unsigned y,
                                               input int unsigned x, input int unsigned h,
                                               input int unsigned w);
    return (c * h + y) * w + x;
  endfunction

endpackage

// File: rtl/pool_flat_buffer.sv
// Flattened pooled-output buffer: one sync write port, sync clear, comb read.
module pool_flat_buffer
  import pool_flatten_pkg::*;
#(
  parameter int unsigned Depth = 256,
  parameter int unsigned Width = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      we_i,
  input  logic [clog2(Depth)-1:0]   waddr_i,
  input  logic [Width-1:0]          wdata_i,
  input  logic [31:0]               raddr_i,
  output logic [Width-1:0]          rdata_o
);

  localparam int unsigned AddrW = clog2(Depth);

  logic [Width-1:0] mem_q [Depth];

  // Storage: clear everything on reset, otherwise single-entry write.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(Depth); i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Zero-latency read; indices past the end read as zero.
  always_comb begin
    rdata_o = '0;
    if (raddr_i < 32'(Depth)) begin
      rdata_o = mem_q[raddr_i[AddrW-1:0]];
    end
  end

endmodule

// File: rtl/maxpool2x2_flatten_responder.sv
// Reads a channel-major feature map, 2x2/stride-2 max-pools it into a flat
// buffer, pulses mp_done, then serves combinational reads from the buffer.
module maxpool2x2_flatten_responder
  import pool_flatten_pkg::*;
#(
  parameter int unsigned IN_H      = 16,
  parameter int unsigned IN_W      = 16,
  parameter int unsigned CHANNELS  = 4,
  parameter int unsigned DATA_W    = DataW,
  parameter int unsigned FM_ADDR_W = 12
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 mp_start,
  output logic                 mp_done,
  input  logic [31:0]          mp_read_addr,
  output logic [DATA_W-1:0]    mp_read_data,
  output logic [FM_ADDR_W-1:0] fm_addr,
  input  logic [DATA_W-1:0]    fm_data,
  output logic                 busy
);

  localparam int unsigned OUT_H   = IN_H / 2;
  localparam int unsigned OUT_W   = IN_W / 2;
  localparam int unsigned OUT_LEN = CHANNELS * OUT_H * OUT_W;
  localparam int unsigned BUF_AW  = clog2(OUT_LEN);
  localparam int unsigned XW      = clog2(OUT_W);
  localparam int unsigned YW      = clog2(OUT_H);
  localparam int unsigned CW      = clog2(CHANNELS);

  logic [1:0]           state_q, state_d;
  logic [1:0]           j_q, j_d;
  logic [XW-1:0]        ox_q, ox_d, nx_ox;
  logic [YW-1:0]        oy_q, oy_d, nx_oy;
  logic [CW-1:0]        c_q, c_d, nx_c;
  logic [BUF_AW-1:0]    idx_q, idx_d;
  logic [DATA_W-1:0]    run_q, run_d;
  logic [FM_ADDR_W-1:0] fm_addr_q, fm_addr_d;

  logic [1:0]           jn;
  logic [FM_ADDR_W-1:0] issue_addr, next_win_addr;
  logic [DATA_W-1:0]    max_val;
  logic                 buf_we;

  // Window-coordinate successor and the addresses the ISSUE/DRAIN edges load.
  always_comb begin
    nx_ox = ox_q + XW'(1);
    nx_oy = oy_q;
    nx_c  = c_q;
    if (ox_q == XW'(OUT_W - 1)) begin
      nx_ox = '0;
      if (oy_q == YW'(OUT_H - 1)) begin
        nx_oy = '0;
        nx_c  = c_q + CW'(1);
      end else begin
        nx_oy = oy_q + YW'(1);
      end
    end
    jn = j_q + 2'd1;
    // Pixel j sits at (2oy + j[1], 2ox + j[0]).
    issue_addr    = FM_ADDR_W'(fm_addr_calc(32'(c_q), 32'({oy_q, jn[1]}),
                                            32'({ox_q, jn[0]}), IN_H, IN_W));
    next_win_addr = FM_ADDR_W'(fm_addr_calc(32'(nx_c), 32'({nx_oy, 1'b0}),
                                            32'({nx_ox, 1'b0}), IN_H, IN_W));
    max_val = (fm_data > run_q) ? fm_data : run_q;
  end

  // Next-state logic for the issue/drain sequencer.
  always_comb begin
    state_d   = state_q;
    j_d       = j_q;
    ox_d      = ox_q;
    oy_d      = oy_q;
    c_d       = c_q;
    idx_d     = idx_q;
    run_d     = run_q;
    fm_addr_d = fm_addr_q;
    case (state_q)
      StIdle: begin
        if (mp_start) begin
          state_d   = StIssue;
          j_d       = '0;
          ox_d      = '0;
          oy_d      = '0;
          c_d       = '0;
          idx_d     = '0;
          fm_addr_d = FM_ADDR_W'(fm_addr_calc(0, 0, 0, IN_H, IN_W));
        end
      end
      StIssue: begin
        // Data lags the address by one cycle: j=1 sees pixel 0's data.
        if (j_q == 2'd1) begin
          run_d = fm_data;
        end else if (j_q != 2'd0) begin
          run_d = max_val;
        end
        j_d = jn;
        if (j_q == 2'd3) begin
          state_d = StDrain;
        end else begin
          fm_addr_d = issue_addr;
        end
      end
      StDrain: begin
        if (idx_q == BUF_AW'(OUT_LEN - 1)) begin
          state_d = StDone;
        end else begin
          state_d   = StIssue;
          ox_d      = nx_ox;
          oy_d      = nx_oy;
          c_d       = nx_c;
          idx_d     = idx_q + BUF_AW'(1);
          fm_addr_d = next_win_addr;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      j_q       <= '0;
      ox_q      <= '0;
      oy_q      <= '0;
      c_q       <= '0;
      idx_q     <= '0;
      run_q     <= '0;
      fm_addr_q <= '0;
    end else begin
      state_q   <= state_d;
      j_q       <= j_d;
      ox_q      <= ox_d;
      oy_q      <= oy_d;
      c_q       <= c_d;
      idx_q     <= idx_d;
      run_q     <= run_d;
      fm_addr_q <= fm_addr_d;
    end
  end

  assign buf_we  = (state_q == StDrain);
  assign mp_done = (state_q == StDone);
  assign busy    = (state_q != StIdle);
  assign fm_addr = fm_addr_q;

  pool_flat_buffer #(
    .Depth (OUT_LEN),
    .Width (DATA_W)
  ) u_buffer (
    .clk_i   (clk),
    .rst_i   (reset),
    .we_i    (buf_we),
    .waddr_i (idx_q),
    .wdata_i (max_val),
    .raddr_i (mp_read_addr),
    .rdata_o (mp_read_data)
  );

endmodule

// File: tb/tb_maxpool2x2_flatten_responder.sv
// Directed self-checking bench for maxpool2x2_flatten_responder.
module tb_maxpool2x2_flatten_responder;
  import pool_flatten_pkg::*;

  localparam int OutLen  = 256;
  localparam int DoneLat = 1281;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mp_start = 1'b0;
  logic        mp_done;
  logic [31:0] mp_read_addr = '0;
  logic [3:0]  mp_read_data;
  logic [11:0] fm_addr;
  logic [3:0]  fm_data;
  logic        busy;

  logic [3:0]  fmap [4096];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Upstream memory: data valid one cycle after the address.
  always @(posedge clk) fm_data <= fmap[fm_addr];

  maxpool2x2_flatten_responder dut (
    .clk          (clk),
    .reset        (reset),
    .mp_start     (mp_start),
    .mp_done      (mp_done),
    .mp_read_addr (mp_read_addr),
    .mp_read_data (mp_read_data),
    .fm_addr      (fm_addr),
    .fm_data      (fm_data),
    .busy         (busy)
  );

  // kind: 0 all 3, 1 x%7 in channel 0, 2 single hot pixel, 3 all 5
  task automatic set_map(input int kind);
    for (int a = 0; a < 4096; a++) begin
      int c, x;
      c = a / 256;
      x = a % 16;
      case (kind)
        0: fmap[a] = 4'd3;
        1: fmap[a] = (c == 0) ? 4'(x % 7) : 4'd0;
        2: fmap[a] = (a == (2 * 16 + 5) * 16 + 9) ? Relu6Max : 4'd0;
        default: fmap[a] = 4'd5;
      endcase
    end
  endtask

  // Reference pooled value built from the bench's own map.
  function automatic logic [3:0] pool_ref(input int idx);
    int c, oy, ox;
    logic [3:0] m, v;
    c = idx / 64; oy = (idx / 8) % 8; ox = idx % 8;
    m = 4'd0;
    for (int dy = 0; dy < 2; dy++)
      for (int dx = 0; dx < 2; dx++) begin
        v = fmap[(c * 16 + 2 * oy + dy) * 16 + 2 * ox + dx];
        if (v > m) m = v;
      end
    return m;
  endfunction

  // Start is sampled at edge k; returns #1 into cycle k+1.
  task automatic pulse_start(input bit hold);
    @(negedge clk);
    mp_start = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) mp_start = 1'b0;
  endtask

  // Observes cycles 1..limit relative to the call point.
  task automatic run_watch(input int limit, output int done_at, output int pulses,
                           output int busy_cnt);
    done_at = -1; pulses = 0; busy_cnt = 0;
    for (int n = 1; n <= limit; n++) begin
      if (n > 1) begin @(posedge clk); #1; end
      if (mp_done === 1'b1) begin
        pulses++;
        if (done_at < 0) done_at = n;
      end
      if (busy === 1'b1) busy_cnt++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (mp_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", mp_done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (fm_addr !== 12'd0) begin errors++; $display("FAIL reset_fm_addr got %0d exp 0", fm_addr); end
    mp_read_addr = 32'd0; #1;
    checks++; if (mp_read_data !== 4'd0) begin errors++; $display("FAIL reset_rd0 got %0d exp 0", mp_read_data); end
    mp_read_addr = 32'd255; #1;
    checks++; if (mp_read_data !== 4'd0) begin errors++; $display("FAIL reset_rd255 got %0d exp 0", mp_read_data); end
    reset = 1'b0;
  endtask

  task automatic test_constant();
    int done_at, pulses, busy_cnt;
    set_map(0);
    pulse_start(1'b0);
    run_watch(DoneLat + 9, done_at, pulses, busy_cnt);
    checks++; if (done_at != DoneLat) begin errors++; $display("FAIL const_done_cycle got %0d exp %0d", done_at, DoneLat); end
    checks++; if (pulses != 1) begin errors++; $display("FAIL const_done_pulses got %0d exp 1", pulses); end
    checks++; if (busy_cnt != DoneLat) begin errors++; $display("FAIL const_busy_cycles got %0d exp %0d", busy_cnt, DoneLat); end
    checks++; if (fm_addr !== 12'd1023) begin errors++; $display("FAIL const_fm_addr_hold got %0d exp 1023", fm_addr); end
    for (int i = 0; i < OutLen; i++) begin
      mp_read_addr = 32'(i); #1;
      checks++; if (mp_read_data !== 4'd3) begin errors++; $display("FAIL const_rd[%0d] got %0d exp 3", i, mp_read_data); end
    end
    mp_read_addr = 32'd256; #1;
    checks++; if (mp_read_data !== 4'd0) begin errors++; $display("FAIL oob_256 got %0d exp 0", mp_read_data); end
    mp_read_addr = 32'd300; #1;
    checks++; if (mp_read_data !== 4'd0) begin errors++; $display("FAIL oob_300 got %0d exp 0", mp_read_data); end
    mp_read_addr = 32'hFFFF_FFFF; #1;
    checks++; if (mp_read_data !== 4'd0) begin errors++; $display("FAIL oob_max got %0d exp 0", mp_read_data); end
  endtask

  task automatic test_read_during_run();
    int done_at;
    set_map(1);
    pulse_start(1'b0);
    for (int n = 2; n <= 100; n++) begin @(posedge clk); #1; end
    mp_read_addr = 32'd0; #1;
    checks++; if (mp_read_data !== 4'd1) begin errors++; $display("FAIL mid_rd0 got %0d exp 1", mp_read_data); end
    mp_read_addr = 32'd18; #1;
    checks++; if (mp_read_data !== 4'd5) begin errors++; $display("FAIL mid_rd18 got %0d exp 5", mp_read_data); end
    mp_read_addr = 32'd19; #1;
    checks++; if (mp_read_data !== 4'd3) begin errors++; $display("FAIL mid_rd19_old got %0d exp 3", mp_read_data); end
    mp_read_addr = 32'd200; #1;
    checks++; if (mp_read_data !== 4'd3) begin errors++; $display("FAIL mid_rd200_old got %0d exp 3", mp_read_data); end
    @(posedge clk); #1;
    mp_read_addr = 32'd19; #1;
    checks++; if (mp_read_data !== 4'd6) begin errors++; $display("FAIL mid_rd19_new got %0d exp 6", mp_read_data); end
    mp_read_addr = 32'd20; #1;
    checks++; if (mp_read_data !== 4'd3) begin errors++; $display("FAIL mid_rd20_old got %0d exp 3", mp_read_data); end
    done_at = -1;
    for (int n = 102; n <= DoneLat + 9; n++) begin
      @(posedge clk); #1;
      if (mp_done === 1'b1 && done_at < 0) done_at = n;
    end
    checks++; if (done_at != DoneLat) begin errors++; $display("FAIL pat_done_cycle got %0d exp %0d", done_at, DoneLat); end
    mp_read_addr = 32'd1; #1;
    checks++; if (mp_read_data !== 4'd3) begin errors++; $display("FAIL pat_rd1 got %0d exp 3", mp_read_data); end
    mp_read_addr = 32'd3; #1;
    checks++; if (mp_read_data !== 4'd6) begin errors++; $display("FAIL pat_rd3 got %0d exp 6", mp_read_data); end
    mp_read_addr = 32'd64; #1;
    checks++; if (mp_read_data !== 4'd0) begin errors++; $display("FAIL pat_rd64 got %0d exp 0", mp_read_data); end
    for (int i = 0; i < OutLen; i++) begin
      mp_read_addr = 32'(i); #1;
      checks++; if (mp_read_data !== pool_ref(i)) begin errors++; $display("FAIL pat_rd[%0d] got %0d exp %0d", i, mp_read_data, pool_ref(i)); end
    end
  endtask

  task automatic test_hot_pixel();
    int done_at, pulses, busy_cnt;
    logic [3:0] exp;
    set_map(2);
    pulse_start(1'b0);
    run_watch(DoneLat + 4, done_at, pulses, busy_cnt);
    checks++; if (done_at != DoneLat) begin errors++; $display("FAIL hot_done_cycle got %0d exp %0d", done_at, DoneLat); end
    for (int i = 0; i < OutLen; i++) begin
      exp = (i == 148) ? 4'd6 : 4'd0;
      mp_read_addr = 32'(i); #1;
      checks++; if (mp_read_data !== exp) begin errors++; $display("FAIL hot_rd[%0d] got %0d exp %0d", i, mp_read_data, exp); end
    end
    mp_read_addr = 32'd300; #1;
    checks++; if (mp_read_data !== 4'd0) begin errors++; $display("FAIL hot_oob_300 got %0d exp 0", mp_read_data); end
  endtask

  task automatic test_reset_mid();
    int done_at, pulses, busy_cnt;
    set_map(3);
    pulse_start(1'b0);
    for (int n = 2; n <= 399; n++) begin @(posedge clk); #1; end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rstmid_busy_before got %b exp 1", busy); end
    reset = 1'b1;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy_after got %b exp 0", busy); end
    checks++; if (mp_done !== 1'b0) begin errors++; $display("FAIL rstmid_done got %b exp 0", mp_done); end
    reset = 1'b0;
    run_watch(DoneLat + 20, done_at, pulses, busy_cnt);
    checks++; if (pulses != 0) begin errors++; $display("FAIL rstmid_no_done got %0d exp 0", pulses); end
    checks++; if (busy_cnt != 0) begin errors++; $display("FAIL rstmid_idle_busy got %0d exp 0", busy_cnt); end
    for (int i = 0; i < OutLen; i++) begin
      mp_read_addr = 32'(i); #1;
      checks++; if (mp_read_data !== 4'd0) begin errors++; $display("FAIL rstmid_rd[%0d] got %0d exp 0", i, mp_read_data); end
    end
    pulse_start(1'b0);
    run_watch(DoneLat + 4, done_at, pulses, busy_cnt);
    checks++; if (done_at != DoneLat) begin errors++; $display("FAIL rstmid_rerun_done got %0d exp %0d", done_at, DoneLat); end
    mp_read_addr = 32'd10; #1;
    checks++; if (mp_read_data !== 4'd5) begin errors++; $display("FAIL rstmid_rerun_rd10 got %0d exp 5", mp_read_data); end
  endtask

  task automatic test_back_to_back();
    int first_done, second_done, pulses;
    logic busy_gap;
    set_map(0);
    pulse_start(1'b1);
    first_done = -1; second_done = -1; pulses = 0; busy_gap = 1'bx;
    for (int n = 1; n <= 2 * DoneLat + 20; n++) begin
      if (n > 1) begin @(posedge clk); #1; end
      if (mp_done === 1'b1) begin
        pulses++;
        if (first_done < 0) first_done = n;
        else if (second_done < 0) second_done = n;
      end
      if (n == DoneLat + 1) busy_gap = busy;
      if (n == 2 * DoneLat + 1) mp_start = 1'b0;
    end
    mp_start = 1'b0;
    checks++; if (first_done != DoneLat) begin errors++; $display("FAIL b2b_first_done got %0d exp %0d", first_done, DoneLat); end
    checks++; if (busy_gap !== 1'b0) begin errors++; $display("FAIL b2b_idle_gap_busy got %b exp 0", busy_gap); end
    checks++; if (second_done != 2 * DoneLat + 1) begin errors++; $display("FAIL b2b_second_done got %0d exp %0d", second_done, 2 * DoneLat + 1); end
    checks++; if (pulses != 2) begin errors++; $display("FAIL b2b_pulses got %0d exp 2", pulses); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_final_busy got %b exp 0", busy); end
    mp_read_addr = 32'd77; #1;
    checks++; if (mp_read_data !== 4'd3) begin errors++; $display("FAIL b2b_rd77 got %0d exp 3", mp_read_data); end
  endtask

  initial begin
    set_map(0);
    test_reset();
    test_constant();
    test_read_during_run();
    test_hot_pixel();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
